exec_sequencer: RTL
===================

Name: exec_sequencer

Overview:
- Multi-cycle execute-phase controller for the 32-bit ALU and its Y/Z registers in the datapath.
- Accepts one ALU-class instruction per start handshake and latches its opcode.
- Sequences operand transfers over the bus, drives the ALU opcode and loads Z.
- Writes results back to the GP register file, or to HI/LO for mul/div, then pulses done.

Parameters:
- MULDIV_LAT, 2, extra hold cycles in S_WAIT for mul/div before Zin. Legal range 0..15.
- CNT_W, 4, width of the wait counter. Must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  request to execute; sampled only in S_IDLE.
- opcode_in  in  5  instruction opcode, latched on an accepted start.
- busy  out  1  high in every state except S_IDLE.
- done  out  1  one-cycle pulse in S_DONE.
- illegal  out  1  high together with done when the latched opcode is not ALU-class.
- alu_opcode  out  5  latched opcode to the ALU; 0 in S_IDLE.
- RAout  out  1  gate Ra onto bus.
- RBout  out  1  gate Rb onto bus.
- Cout  out  1  gate sign-extended immediate onto bus.
- Yin  out  1  load Y.
- Zin  out  1  load Z (64-bit).
- Zlowout  out  1  gate Z[31:0] onto bus.
- Zhighout  out  1  gate Z[63:32] onto bus.
- Rin  out  1  write bus to Rd.
- LOin  out  1  write bus to LO.
- HIin  out  1  write bus to HI.
- perf_ops  out  32  completed-op count (see Optional Feature).

Behaviour:
- Reset: clr=0 forces S_IDLE immediately (asynchronous); all outputs 0; latched opcode 0; wait counter 0. Reset mid-operation abandons the op with no done pulse.
- All control outputs are registered-state Moore decodes; no output depends combinationally on start.
- Opcode classes:
  - BIN: add, sub, and, or, shr, shra, shl, ror, rol.
  - IMM: addi, andi, ori.
  - UNARY: neg, not.
  - MULDIV: mul, div.
  - ILLEGAL: everything else (load, loadi, store, branch, jr, jal, in, out, mfhi, mflo, nop, halt).
- S_IDLE: when start=1, latch opcode_in and go to:
  - S_RA for BIN, IMM and MULDIV.
  - S_OP for UNARY.
  - S_DONE with illegal=1 for ILLEGAL.
- S_RA: RAout=1, Yin=1 -> S_OP.
- S_OP:
  - Bus source: RBout=1, or Cout=1 for IMM.
  - alu_opcode valid.
  - Zin=1, except for MULDIV when MULDIV_LAT>0.
  - Next: MULDIV with MULDIV_LAT>0 -> S_WAIT (counter=MULDIV_LAT-1); otherwise -> S_WB_LO.
- S_WAIT:
  - Operand source and alu_opcode held stable.
  - counter decrements each cycle.
  - Zin=1 on the cycle counter==0, then -> S_WB_LO.
- S_WB_LO: Zlowout=1; Rin=1 for non-MULDIV, LOin=1 for MULDIV. MULDIV -> S_WB_HI; others -> S_DONE.
- S_WB_HI: Zhighout=1, HIin=1 -> S_DONE.
- S_DONE: done=1 (illegal=1 if ILLEGAL), busy=1 -> S_IDLE.
- Latency from the accepted-start edge to the done cycle:
  - BIN and IMM: 4 cycles.
  - UNARY: 3 cycles.
  - MULDIV: 5+MULDIV_LAT cycles.
  - ILLEGAL: 1 cycle.
- start while busy=1 is ignored, with no queueing. start on the S_DONE cycle is also ignored; the next accept is possible in S_IDLE, one cycle after done.
- opcode_in changes after acceptance have no effect.
- At most one of RAout/RBout/Cout/Zlowout/Zhighout is high in any cycle.

Optional Feature:
- Macro: EXEC_SEQ_PERF_CNT_EN.
- Defined: perf_ops increments by 1 in each S_DONE with illegal=0. It wraps modulo 2^32 and resets to 0 on clr.
- Undefined: perf_ops is tied to 32'd0 and no counter flops are synthesised.

Decomposition:
- Package exec_seq_pkg holds:
  - The 5-bit opcode constants, matching the ALU encoding (add=00011 … halt=11011).
  - The state encoding S_IDLE..S_DONE.
  - The op-class enum BIN/IMM/UNARY/MULDIV/ILLEGAL.
- One sub-module, exec_op_decode: combinational opcode -> op-class mapping, reused by the control unit.

Test Plan:
- add (00011), start for 1 cycle:
  - RAout+Yin on cycle 1; RBout+Zin+alu_opcode=00011 on cycle 2; Zlowout+Rin on cycle 3; done on cycle 4.
  - Never LOin or HIin.
- addi (01100): identical timing; Cout=1 and RBout=0 in S_OP.
- not (10010): no RAout/Yin at all; done on cycle 3.
- mul (01111), MULDIV_LAT=2:
  - Zin only on cycle 4.
  - LOin+Zlowout on cycle 5; HIin+Zhighout on cycle 6; done on cycle 7.
  - Repeat with MULDIV_LAT=0: Zin on cycle 2, done on cycle 5.
- halt (11011): done=illegal=1 on cycle 1, no datapath strobes.
  - start held high continuously: ops accepted every other cycle after done.
- Reset mid-op:
  - clr low during S_WAIT of div: all outputs 0 asynchronously.
  - After clr release, start with sub completes normally and no stale done appears.
  - With EXEC_SEQ_PERF_CNT_EN: perf_ops returns to 0 and counts 3 after three legal ops.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// rtl/exec_seq_pkg.sv - shared opcode, state, op-class and control-word types for exec_sequencer
// Purpose : common definitions imported by exec_op_decode and exec_sequencer.
// Ports   : none (package).
package exec_seq_pkg;

   // 5-bit opcodes, matching the ALU encoding
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [2:0] {
      S_IDLE, S_RA, S_OP, S_WAIT, S_WB_LO, S_WB_HI, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      BIN, IMM, UNARY, MULDIV, ILLEGAL
   } op_class_t;

   // Registered control word; every field is a Moore decode of the next state.
   typedef struct packed {
      logic       busy;
      logic       done;
      logic       illegal;
      logic       ra_out;
      logic       rb_out;
      logic       c_out;
      logic       y_in;
      logic       z_in;
      logic       zlow_out;
      logic       zhigh_out;
      logic       r_in;
      logic       lo_in;
      logic       hi_in;
      logic [4:0] alu_opcode;
   } ctrl_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - start/opcode request and datapath control strobe bundle
// Purpose : groups the request handshake and all control outputs of exec_sequencer.
// Signals : start, opcode_in (request); busy, done, illegal, alu_opcode, bus gates
//           RAout/RBout/Cout/Zlowout/Zhighout, register loads Yin/Zin/Rin/LOin/HIin,
//           perf_ops (completed-op count).
// Modports: slave  - the sequencer (drives control, receives request)
//           master - the requester/observer (drives request, receives control)
interface exec_sequencer_if;
   logic        start;
   logic [4:0]  opcode_in;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [4:0]  alu_opcode;
   logic        RAout;
   logic        RBout;
   logic        Cout;
   logic        Yin;
   logic        Zin;
   logic        Zlowout;
   logic        Zhighout;
   logic        Rin;
   logic        LOin;
   logic        HIin;
   logic [31:0] perf_ops;

   modport slave (
      input  start, opcode_in,
      output busy, done, illegal, alu_opcode,
      output RAout, RBout, Cout, Yin, Zin, Zlowout, Zhighout, Rin, LOin, HIin,
      output perf_ops
   );

   modport master (
      output start, opcode_in,
      input  busy, done, illegal, alu_opcode,
      input  RAout, RBout, Cout, Yin, Zin, Zlowout, Zhighout, Rin, LOin, HIin,
      input  perf_ops
   );
endinterface

// File: rtl/exec_op_decode.sv
// rtl/exec_op_decode.sv - combinational opcode to op-class mapping
// Purpose : classifies a 5-bit opcode into BIN/IMM/UNARY/MULDIV/ILLEGAL.
// Ports   : opcode (in, 5) - opcode to classify
//           op_class (out)  - resulting class
module exec_op_decode
   import exec_seq_pkg::*;
(
   input  logic [4:0] opcode,
   output op_class_t  op_class
);

   always_comb begin
      op_class = ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:       op_class = BIN;
         OP_ADDI, OP_ANDI, OP_ORI:              op_class = IMM;
         OP_NEG, OP_NOT:                        op_class = UNARY;
         OP_MUL, OP_DIV:                        op_class = MULDIV;
         default:                               op_class = ILLEGAL;
      endcase
   end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle execute-phase controller for the ALU and Y/Z registers
// Purpose : accepts one ALU-class op per start, sequences operand transfers, ALU op,
//           Z load and write-back (Rd, or LO/HI for mul/div), then pulses done.
// Ports   : clk - rising-edge clock
//           clr - asynchronous active-low reset
//           bus - exec_sequencer_if.slave (request in, registered control strobes out)
// Params  : MULDIV_LAT - extra S_WAIT hold cycles for mul/div (0..15)
//           CNT_W      - wait counter width, 2**CNT_W > MULDIV_LAT
// Config  : EXEC_SEQ_PERF_CNT_EN - when defined, perf_ops counts legal completed ops;
//           otherwise perf_ops is constant zero.
module exec_sequencer
   import exec_seq_pkg::*;
#(
   parameter int MULDIV_LAT = 2,
   parameter int CNT_W      = 4
) (
   input  logic               clk,
   input  logic               clr,
   exec_sequencer_if.slave    bus
);

   localparam bit               HAS_WAIT  = (MULDIV_LAT > 0);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(HAS_WAIT ? MULDIV_LAT - 1 : 0);

   state_t           state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d;
   op_class_t        cls_d;
   logic             accept;
   logic             src_phase;

   // The opcode is captured only on an accepted start, so later opcode_in changes are inert.
   assign accept = (state_q == S_IDLE) && bus.start;
   assign op_d   = accept ? bus.opcode_in : op_q;

   exec_op_decode u_decode (
      .opcode   (op_d),
      .op_class (cls_d)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               case (cls_d)
                  BIN, IMM, MULDIV: state_d = S_RA;
                  UNARY:            state_d = S_OP;
                  default:          state_d = S_DONE;
               endcase
            end
         end
         S_RA:    state_d = S_OP;
         S_OP: begin
            if (cls_d == MULDIV && HAS_WAIT) begin
               state_d = S_WAIT;
               cnt_d   = WAIT_INIT;
            end else begin
               state_d = S_WB_LO;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_WB_LO;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_WB_LO: state_d = (cls_d == MULDIV) ? S_WB_HI : S_DONE;
         S_WB_HI: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered strobes line up with state_q.
   always_comb begin
      ctrl_d    = '0;
      src_phase = (state_d == S_OP) || (state_d == S_WAIT);

      ctrl_d.busy       = (state_d != S_IDLE);
      ctrl_d.done       = (state_d == S_DONE);
      ctrl_d.illegal    = (state_d == S_DONE) && (cls_d == ILLEGAL);
      ctrl_d.ra_out     = (state_d == S_RA);
      ctrl_d.y_in       = (state_d == S_RA);
      // Operand source stays asserted through S_WAIT so the ALU inputs are stable.
      ctrl_d.rb_out     = src_phase && (cls_d != IMM);
      ctrl_d.c_out      = src_phase && (cls_d == IMM);
      // Mul/div with latency loads Z at the end of S_WAIT instead of in S_OP.
      ctrl_d.z_in       = ((state_d == S_OP) && !(cls_d == MULDIV && HAS_WAIT)) ||
                          ((state_d == S_WAIT) && (cnt_d == '0));
      ctrl_d.zlow_out   = (state_d == S_WB_LO);
      ctrl_d.r_in       = (state_d == S_WB_LO) && (cls_d != MULDIV);
      ctrl_d.lo_in      = (state_d == S_WB_LO) && (cls_d == MULDIV);
      ctrl_d.zhigh_out  = (state_d == S_WB_HI);
      ctrl_d.hi_in      = (state_d == S_WB_HI);
      ctrl_d.alu_opcode = (state_d == S_IDLE) ? 5'd0 : op_d;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.busy       = ctrl_q.busy;
   assign bus.done       = ctrl_q.done;
   assign bus.illegal    = ctrl_q.illegal;
   assign bus.alu_opcode = ctrl_q.alu_opcode;
   assign bus.RAout      = ctrl_q.ra_out;
   assign bus.RBout      = ctrl_q.rb_out;
   assign bus.Cout       = ctrl_q.c_out;
   assign bus.Yin        = ctrl_q.y_in;
   assign bus.Zin        = ctrl_q.z_in;
   assign bus.Zlowout    = ctrl_q.zlow_out;
   assign bus.Zhighout   = ctrl_q.zhigh_out;
   assign bus.Rin        = ctrl_q.r_in;
   assign bus.LOin       = ctrl_q.lo_in;
   assign bus.HIin       = ctrl_q.hi_in;

`ifdef EXEC_SEQ_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   // Counts while leaving S_DONE, so the new total is visible the cycle after done.
   assign perf_d = (ctrl_q.done && !ctrl_q.illegal) ? perf_q + 32'd1 : perf_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) perf_q <= '0;
      else      perf_q <= perf_d;
   end

   assign bus.perf_ops = perf_q;
`else
   assign bus.perf_ops = 32'd0;
`endif

endmodule
